// File: rtl/addsub_seq.sv
// addsub_seq: multi-cycle WIDTH-bit adder/subtractor producing NZCV flags.
// Each RUN cycle adds one CHUNK-bit slice, LSB slice first, and ripples the
// carry through a register. This keeps the per-cycle carry chain CHUNK bits long.
// Valid/ready handshake on both sides. Reset is asynchronous and active-low.
// Optional feature macro: ADDSUB_SEQ_SAT_EN adds a 'saturate' input. When that
// input is set and the operation overflows, the result is clamped on entry to DONE.
module addsub_seq #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
`ifdef ADDSUB_SEQ_SAT_EN
  input  logic             saturate,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             negative,
  output logic             zero,
  output logic             overflow,
  output logic             carry_out
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  if ((WIDTH % CHUNK) != 0 || NCHUNK < 1 || NCHUNK > 64) begin : g_bad_params
    $error("addsub_seq: WIDTH must be a multiple of CHUNK with 1..64 chunks");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;      // B already inverted for subtraction
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             zero_acc;   // 1 while every chunk summed so far was zero
`ifdef ADDSUB_SEQ_SAT_EN
  logic             sat_reg;
`endif

  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK:0]   chunk_sum;
  logic             last_chunk;
  logic             msb_carry_in;
  logic             raw_overflow;
  logic             do_clamp;
  logic [WIDTH-1:0] clamp_value;

  // Slice adder for the current chunk plus last-chunk flag derivation.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    a_chunk      = a_reg[cnt*CHUNK +: CHUNK];
    b_chunk      = b_reg[cnt*CHUNK +: CHUNK];
    chunk_sum    = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry};
    last_chunk   = (cnt == LAST);
    // Carry into the MSB is recovered from the MSB sum bit and its two addends.
    msb_carry_in = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ chunk_sum[CHUNK-1];
    raw_overflow = msb_carry_in ^ chunk_sum[CHUNK];
    // Clamp toward A's sign: 0111..1 for non-negative A, 1000..0 for negative A.
    clamp_value  = {a_reg[WIDTH-1], {(WIDTH-1){~a_reg[WIDTH-1]}}};
`ifdef ADDSUB_SEQ_SAT_EN
    do_clamp     = sat_reg & last_chunk & raw_overflow;
`else
    do_clamp     = 1'b0;
`endif
  end

  // Control FSM with datapath registers and registered handshake outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      negative  <= 1'b0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
      carry_out <= 1'b0;
      cnt       <= '0;
      carry     <= 1'b0;
      zero_acc  <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
`ifdef ADDSUB_SEQ_SAT_EN
      sat_reg   <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      unique case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_reg    <= A;
            b_reg    <= sub ? ~B : B;
            carry    <= sub;       // the +1 of the two's-complement negate
            cnt      <= '0;
            zero_acc <= 1'b1;
`ifdef ADDSUB_SEQ_SAT_EN
            sat_reg  <= saturate;
`endif
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          if (do_clamp) begin
            result <= clamp_value;
          end else begin
            result[cnt*CHUNK +: CHUNK] <= chunk_sum[CHUNK-1:0];
          end
          carry    <= chunk_sum[CHUNK];
          zero_acc <= zero_acc & ~|chunk_sum[CHUNK-1:0];
          if (last_chunk) begin
            overflow  <= raw_overflow;
            carry_out <= chunk_sum[CHUNK];
            negative  <= do_clamp ? clamp_value[WIDTH-1] : chunk_sum[CHUNK-1];
            zero      <= do_clamp ? 1'b0 : (zero_acc & ~|chunk_sum[CHUNK-1:0]);
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_seq.sv
// tb_addsub_seq: directed and randomized checks of addsub_seq against a
// whole-word arithmetic reference model. Build with +define+ADDSUB_SEQ_SAT_EN
// to exercise the saturate input as well.
module tb_addsub_seq;

  localparam int W      = 64;
  localparam int CHUNK  = 16;
  localparam int NCHUNK = W / CHUNK;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic         sub;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         saturate;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         negative;
  logic         zero;
  logic         overflow;
  logic         carry_out;

  int checks = 0;
  int errors = 0;

  addsub_seq #(.WIDTH(W), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sub       (sub),
    .A         (A),
    .B         (B),
`ifdef ADDSUB_SEQ_SAT_EN
    .saturate  (saturate),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .negative  (negative),
    .zero      (zero),
    .overflow  (overflow),
    .carry_out (carry_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] res;
    logic         n;
    logic         z;
    logic         v;
    logic         c;
  } exp_t;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Whole-word reference: two's-complement add on W+1 bits, signed overflow
  // from operand/result signs, then optional clamping.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic s, input logic sat);
    exp_t         m;
    logic [W:0]   full;
    logic [W-1:0] bb;
    bb    = s ? ~b : b;
    full  = {1'b0, a} + {1'b0, bb} + (W+1)'(s);
    m.c   = full[W];
    m.res = full[W-1:0];
    m.v   = (a[W-1] == bb[W-1]) && (m.res[W-1] != a[W-1]);
    if (sat && m.v)
      m.res = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    m.n   = m.res[W-1];
    m.z   = (m.res == '0);
    return m;
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return {1'b1, {(W-1){1'b0}}};
      3:       return {1'b0, {(W-1){1'b1}}};
      4:       return W'($urandom_range(0, 20));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic check_result(input string tag, input exp_t e);
    check({tag, "_result"},   result,    e.res);
    check({tag, "_negative"}, negative,  W'(e.n));
    check({tag, "_zero"},     zero,      W'(e.z));
    check({tag, "_overflow"}, overflow,  W'(e.v));
    check({tag, "_carry"},    carry_out, W'(e.c));
  endtask

  // One complete operation: accept, latency, results, optional stall, drain.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic sat, input int hold);
    exp_t e;
    logic early;
`ifdef ADDSUB_SEQ_SAT_EN
    e = model(a, b, s, sat);
`else
    e = model(a, b, s, 1'b0);
`endif
    check({tag, "_in_ready_idle"}, W'(in_ready), W'(1));
    in_valid = 1'b1; A = a; B = b; sub = s; saturate = sat; out_ready = 1'b0;
    @(posedge clk); #1;
    // Scramble inputs while busy; the in-flight op must not see them.
    in_valid = 1'b0; A = {$urandom, $urandom}; B = {$urandom, $urandom};
    sub = 1'($urandom); saturate = 1'($urandom);
    check({tag, "_in_ready_busy"}, W'(in_ready), W'(0));
    early = 1'b0;
    for (int i = 1; i < NCHUNK; i++) begin
      @(posedge clk); #1;
      early |= out_valid;
    end
    check({tag, "_early_valid"}, W'(early), W'(0));
    @(posedge clk); #1;
    check({tag, "_latency"}, W'(out_valid), W'(1));
    check_result(tag, e);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom); A = {$urandom, $urandom};
      @(posedge clk); #1;
      check({tag, "_hold_valid"}, W'(out_valid), W'(1));
      check({tag, "_hold_ready"}, W'(in_ready), W'(0));
      check({tag, "_hold_result"}, result, e.res);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_drain_valid"}, W'(out_valid), W'(0));
    check({tag, "_drain_ready"}, W'(in_ready), W'(1));
    check({tag, "_drain_result"}, result, e.res);
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; sub = 1'b0; A = '0; B = '0;
    saturate = 1'b0; out_ready = 1'b0;
    #12;
    check("rst_in_ready",  W'(in_ready),  W'(1));
    check("rst_out_valid", W'(out_valid), W'(0));
    check("rst_result",    result,        '0);
    check("rst_flags",     W'({negative, zero, overflow, carry_out}), W'(0));
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;

    run_op("sub_5_3", 64'd5, 64'd3, 1'b1, 1'b0, 0);
    check("sub_5_3_const", result, 64'd2);
    run_op("sub_3_5", 64'd3, 64'd5, 1'b1, 1'b0, 0);
    check("sub_3_5_const", result, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op("ovf_add", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 0);
    check("ovf_add_const", result, 64'h8000_0000_0000_0000);
`ifdef ADDSUB_SEQ_SAT_EN
    run_op("sat_add", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b1, 0);
    check("sat_add_const", result, 64'h7FFF_FFFF_FFFF_FFFF);
    run_op("sat_neg", 64'h8000_0000_0000_0000, 64'd1, 1'b1, 1'b1, 0);
    check("sat_neg_const", result, 64'h8000_0000_0000_0000);
`endif
    run_op("ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 0);
    check("ripple_zero_const", W'(zero), W'(1));
    run_op("stall", 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b0, 10);

    // Reset during the second RUN cycle aborts the op immediately.
    in_valid = 1'b1; A = 64'd99; B = 64'd1; sub = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("abort_out_valid", W'(out_valid), W'(0));
    check("abort_in_ready",  W'(in_ready),  W'(1));
    check("abort_result",    result,        '0);
    check("abort_flags",     W'({negative, zero, overflow, carry_out}), W'(0));
    repeat (2) @(posedge clk);
    #1;
    check("abort_no_valid", W'(out_valid), W'(0));
    @(negedge clk); reset = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    run_op("post_rst", 64'd10, 64'd10, 1'b1, 1'b0, 0);
    check("post_rst_zero_const", W'(zero), W'(1));

    for (int i = 0; i < 40; i++) begin
      run_op($sformatf("rnd%0d", i), pick(), pick(), 1'($urandom), 1'($urandom),
             int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
